mesi_isc_snoop_sched: RTL and testbench
=======================================

MESI_ISC_SNOOP_SCHED -- requirements
Module: mesi_isc_snoop_sched

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, giving the width of the main-bus and coherence-bus addresses.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have ports mbus_cmd0_i..mbus_cmd3_i, input, 3 bits each: per-core main-bus command (0 NOP, 1 WR, 2 RD, 3 WR_BROAD, 4 RD_BROAD).
REQ-005 The block SHALL have ports mbus_addr0_i..mbus_addr3_i, input, ADDR_WIDTH bits each: per-core request address.
REQ-006 The block SHALL have ports mbus_ack0_o..mbus_ack3_o, output, 1 bit each: one-cycle grant/acceptance of a core's broadcast request.
REQ-007 The block SHALL have ports cbus_cmd0_o..cbus_cmd3_o, output, 3 bits each: per-core coherence command (0 NOP, 1 WR_SNOOP, 2 RD_SNOOP, 3 EN_WR, 4 EN_RD).
REQ-008 The block SHALL have port cbus_addr_o, output, ADDR_WIDTH bits: address of the transaction in progress.
REQ-009 The block SHALL have ports cbus_ack0_i..cbus_ack3_i, input, 1 bit each: core acknowledge of its current coherence command.
REQ-010 The block SHALL have port busy_o, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-011 All outputs SHALL be registered; the FSM SHALL have states IDLE, SNOOP and ENABLE.
REQ-012 In IDLE, a core SHALL be a candidate only when its mbus_cmd is 3 or 4; values 0, 1, 2 and 5-7 SHALL be ignored, with no mbus_ack.
REQ-013 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod 4; last_grant resets to 3, so core 0 has first priority.
REQ-014 When IDLE sees one or more candidates in cycle n, cycle n+1 SHALL have: mbus_ack of the winner = 1 for exactly one cycle; requester id, type and address latched; state SNOOP.
REQ-015 In cycle n+1, the three non-requester cbus_cmd outputs SHALL be WR_SNOOP for WR_BROAD or RD_SNOOP for RD_BROAD, the requester's cbus_cmd SHALL be NOP, and cbus_addr_o SHALL be the latched address.
REQ-016 In SNOOP, a pending core's cbus_ack_i sampled high in cycle m SHALL clear its pending bit and drive its cbus_cmd to NOP in cycle m+1; acks from non-pending cores SHALL be ignored.
REQ-017 The cycle after the last pending ack is sampled, including when all three acks arrive together, the state SHALL be ENABLE and the requester's cbus_cmd SHALL be EN_WR or EN_RD.
REQ-018 In ENABLE, the requester's cbus_ack_i sampled high in cycle k SHALL give, in cycle k+1: cbus_cmd NOP, state IDLE, and last_grant = requester; the earliest next mbus_ack SHALL be in cycle k+2.
REQ-019 EN commands and snoop commands SHALL be held until acknowledged, with no timeout.
REQ-020 Outside IDLE, mbus_cmd inputs SHALL be ignored; a requester that keeps its broadcast command after mbus_ack competes again only in IDLE.
REQ-021 cbus_addr_o SHALL hold its value from grant until the next grant; mbus_ack outputs SHALL be 0 except in the grant cycle.

Reset
REQ-022 When rst is sampled high, the next cycle SHALL have: state IDLE, all cbus_cmd NOP, all mbus_ack 0, cbus_addr_o 0, busy_o 0, pending mask 0, last_grant 3.
REQ-023 Reset in mid-transaction SHALL abandon the transaction with no further acks or commands.
REQ-024 The first arbitration SHALL occur on the first cycle with rst low.

Verification
REQ-025 Core 0 issues WR_BROAD, addr 0x1000 -> mbus_ack0 pulses; cbus_cmd1..3 = 1 and cbus_addr_o = 0x1000; after acks 1, 2, 3, cbus_cmd0 = 3; after ack0, all NOP.
REQ-026 Cores 1 and 2 issue RD_BROAD together, then keep re-requesting -> grant order 1, 2, 1, 2; snoop commands = 2 and enable = 4.
REQ-027 All three snoop acks arrive in the same cycle -> the next cycle shows snoop commands NOP and requester EN.
REQ-028 Staggered acks (core 3 at t, core 1 at t+2, core 2 at t+5) -> each cbus_cmd drops one cycle after its ack; EN appears at t+6.
REQ-029 rst asserted while in SNOOP -> all outputs 0 the next cycle; a new request after reset is granted to the lowest-index requester.

Source files
------------

// File: rtl/mesi_isc_snoop_sched_if.sv
// Bus bundle between the cores and the coherence snoop scheduler.
// The scheduler connects through the slave modport; the cores/bench through master.
interface mesi_isc_snoop_sched_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [2:0]            mbus_cmd0_i, mbus_cmd1_i, mbus_cmd2_i, mbus_cmd3_i;
    logic [ADDR_WIDTH-1:0] mbus_addr0_i, mbus_addr1_i, mbus_addr2_i, mbus_addr3_i;
    logic                  mbus_ack0_o, mbus_ack1_o, mbus_ack2_o, mbus_ack3_o;
    logic [2:0]            cbus_cmd0_o, cbus_cmd1_o, cbus_cmd2_o, cbus_cmd3_o;
    logic [ADDR_WIDTH-1:0] cbus_addr_o;
    logic                  cbus_ack0_i, cbus_ack1_i, cbus_ack2_i, cbus_ack3_i;
    logic                  busy_o;

    modport slave (
        input  mbus_cmd0_i, mbus_cmd1_i, mbus_cmd2_i, mbus_cmd3_i,
        input  mbus_addr0_i, mbus_addr1_i, mbus_addr2_i, mbus_addr3_i,
        output mbus_ack0_o, mbus_ack1_o, mbus_ack2_o, mbus_ack3_o,
        output cbus_cmd0_o, cbus_cmd1_o, cbus_cmd2_o, cbus_cmd3_o,
        output cbus_addr_o,
        input  cbus_ack0_i, cbus_ack1_i, cbus_ack2_i, cbus_ack3_i,
        output busy_o
    );

    modport master (
        output mbus_cmd0_i, mbus_cmd1_i, mbus_cmd2_i, mbus_cmd3_i,
        output mbus_addr0_i, mbus_addr1_i, mbus_addr2_i, mbus_addr3_i,
        input  mbus_ack0_o, mbus_ack1_o, mbus_ack2_o, mbus_ack3_o,
        input  cbus_cmd0_o, cbus_cmd1_o, cbus_cmd2_o, cbus_cmd3_o,
        input  cbus_addr_o,
        output cbus_ack0_i, cbus_ack1_i, cbus_ack2_i, cbus_ack3_i,
        input  busy_o
    );
endinterface

// File: rtl/mesi_isc_snoop_sched.sv
// Four-core broadcast scheduler: round-robin grant, snoop the other three cores,
// then enable the requester once every snoop is acknowledged.
module mesi_isc_snoop_sched #(
    parameter int ADDR_WIDTH = 32
) (
    input logic                   clk,
    input logic                   rst,
    mesi_isc_snoop_sched_if.slave bus
);
    localparam logic [2:0] MbusWrBroad = 3'd3;
    localparam logic [2:0] MbusRdBroad = 3'd4;
    localparam logic [2:0] CbusNop     = 3'd0;
    localparam logic [2:0] CbusWrSnoop = 3'd1;
    localparam logic [2:0] CbusRdSnoop = 3'd2;
    localparam logic [2:0] CbusEnWr    = 3'd3;
    localparam logic [2:0] CbusEnRd    = 3'd4;

    typedef enum logic [1:0] {StIdle, StSnoop, StEnable} state_e;

    state_e                state_q;
    logic [1:0]            req_q;
    logic                  rd_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [3:0]            pend_q;
    logic [1:0]            last_q;
    logic [3:0]            mack_q;
    logic [2:0]            ccmd_q [4];

    logic [2:0]            cmd_in  [4];
    logic [ADDR_WIDTH-1:0] addr_in [4];
    logic [3:0]            ack_in;
    logic [3:0]            cand;
    logic [1:0]            win, idx;
    logic                  win_vld;

    always_comb begin
        cmd_in[0]  = bus.mbus_cmd0_i;
        cmd_in[1]  = bus.mbus_cmd1_i;
        cmd_in[2]  = bus.mbus_cmd2_i;
        cmd_in[3]  = bus.mbus_cmd3_i;
        addr_in[0] = bus.mbus_addr0_i;
        addr_in[1] = bus.mbus_addr1_i;
        addr_in[2] = bus.mbus_addr2_i;
        addr_in[3] = bus.mbus_addr3_i;
        ack_in     = {bus.cbus_ack3_i, bus.cbus_ack2_i, bus.cbus_ack1_i, bus.cbus_ack0_i};
    end

    // Round-robin search starting one past the last completed requester.
    always_comb begin
        win     = 2'd0;
        win_vld = 1'b0;
        idx     = 2'd0;
        for (int i = 0; i < 4; i++) begin
            cand[i] = (cmd_in[i] == MbusWrBroad) || (cmd_in[i] == MbusRdBroad);
        end
        for (int k = 1; k <= 4; k++) begin
            idx = last_q + 2'(k);
            if (!win_vld && cand[idx]) begin
                win     = idx;
                win_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            req_q   <= 2'd0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            pend_q  <= 4'd0;
            last_q  <= 2'd3;
            mack_q  <= 4'd0;
            for (int j = 0; j < 4; j++) ccmd_q[j] <= CbusNop;
        end else begin
            mack_q <= 4'd0;
            unique case (state_q)
                StIdle: begin
                    if (win_vld) begin
                        mack_q[win] <= 1'b1;
                        req_q       <= win;
                        rd_q        <= (cmd_in[win] == MbusRdBroad);
                        addr_q      <= addr_in[win];
                        pend_q      <= ~(4'd1 << win);
                        state_q     <= StSnoop;
                        for (int j = 0; j < 4; j++) begin
                            if (2'(j) == win) ccmd_q[j] <= CbusNop;
                            else ccmd_q[j] <= (cmd_in[win] == MbusRdBroad) ? CbusRdSnoop
                                                                            : CbusWrSnoop;
                        end
                    end
                end
                StSnoop: begin
                    for (int j = 0; j < 4; j++) begin
                        if (pend_q[j] && ack_in[j]) begin
                            pend_q[j] <= 1'b0;
                            ccmd_q[j] <= CbusNop;
                        end
                    end
                    // Requester is never pending, so this cannot collide with the clears above.
                    if ((pend_q & ~ack_in) == 4'd0) begin
                        state_q       <= StEnable;
                        ccmd_q[req_q] <= rd_q ? CbusEnRd : CbusEnWr;
                    end
                end
                StEnable: begin
                    if (ack_in[req_q]) begin
                        ccmd_q[req_q] <= CbusNop;
                        last_q        <= req_q;
                        state_q       <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.mbus_ack0_o = mack_q[0];
    assign bus.mbus_ack1_o = mack_q[1];
    assign bus.mbus_ack2_o = mack_q[2];
    assign bus.mbus_ack3_o = mack_q[3];
    assign bus.cbus_cmd0_o = ccmd_q[0];
    assign bus.cbus_cmd1_o = ccmd_q[1];
    assign bus.cbus_cmd2_o = ccmd_q[2];
    assign bus.cbus_cmd3_o = ccmd_q[3];
    assign bus.cbus_addr_o = addr_q;
    assign bus.busy_o      = (state_q != StIdle);
endmodule

// File: tb/tb_mesi_isc_snoop_sched.sv
// Random and directed stimulus for the snoop scheduler, checked every cycle
// against a transaction-level model of grant / snoop / enable.
module tb_mesi_isc_snoop_sched;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mesi_isc_snoop_sched_if #(.ADDR_WIDTH(32)) bus ();
    mesi_isc_snoop_sched #(.ADDR_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    // Stimulus for the next edge.
    logic        rst_v;
    logic [2:0]  cmd_v  [4];
    logic [31:0] addr_v [4];
    logic [3:0]  ack_v;

    // Model: phase 0 idle, 1 snooping, 2 enabling.
    int          m_ph   = 0;
    int          m_req  = 0;
    bit          m_rd   = 0;
    logic [31:0] m_addr = 0;
    bit          m_pend [4];
    int          m_last = 3;
    bit [3:0]    m_gnt  = 0;

    int grants[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [3:0] dut_mack();
        return {bus.mbus_ack3_o, bus.mbus_ack2_o, bus.mbus_ack1_o, bus.mbus_ack0_o};
    endfunction

    function automatic logic [2:0] dut_cmd(input int j);
        case (j)
            0: return bus.cbus_cmd0_o;
            1: return bus.cbus_cmd1_o;
            2: return bus.cbus_cmd2_o;
            default: return bus.cbus_cmd3_o;
        endcase
    endfunction

    task automatic model_step();
        m_gnt = 0;
        if (rst_v) begin
            m_ph = 0; m_last = 3; m_addr = 0; m_req = 0; m_rd = 0;
            foreach (m_pend[j]) m_pend[j] = 0;
        end else if (m_ph == 0) begin
            int best = -1;
            for (int off = 1; off <= 4; off++) begin
                int c = (m_last + off) % 4;
                if (best < 0 && (cmd_v[c] == 3 || cmd_v[c] == 4)) best = c;
            end
            if (best >= 0) begin
                m_gnt[best] = 1;
                m_req  = best;
                m_rd   = (cmd_v[best] == 4);
                m_addr = addr_v[best];
                foreach (m_pend[j]) m_pend[j] = (j != best);
                m_ph = 1;
            end
        end else if (m_ph == 1) begin
            int left = 0;
            foreach (m_pend[j]) begin
                if (ack_v[j]) m_pend[j] = 0;
                left += int'(m_pend[j]);
            end
            if (left == 0) m_ph = 2;
        end else if (ack_v[m_req]) begin
            m_last = m_req;
            m_ph   = 0;
        end
    endtask

    task automatic check_all();
        check_eq("mack", 64'(dut_mack()), 64'(m_gnt));
        for (int j = 0; j < 4; j++) begin
            int e = 0;
            if (m_ph == 1 && m_pend[j]) e = m_rd ? 2 : 1;
            else if (m_ph == 2 && j == m_req) e = m_rd ? 4 : 3;
            check_eq($sformatf("cmd%0d", j), 64'(dut_cmd(j)), 64'(e));
        end
        check_eq("addr", 64'(bus.cbus_addr_o), 64'(m_addr));
        check_eq("busy", 64'(bus.busy_o), 64'(m_ph != 0));
    endtask

    task automatic tick();
        rst = rst_v;
        bus.mbus_cmd0_i = cmd_v[0];  bus.mbus_addr0_i = addr_v[0];
        bus.mbus_cmd1_i = cmd_v[1];  bus.mbus_addr1_i = addr_v[1];
        bus.mbus_cmd2_i = cmd_v[2];  bus.mbus_addr2_i = addr_v[2];
        bus.mbus_cmd3_i = cmd_v[3];  bus.mbus_addr3_i = addr_v[3];
        {bus.cbus_ack3_i, bus.cbus_ack2_i, bus.cbus_ack1_i, bus.cbus_ack0_i} = ack_v;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
        for (int j = 0; j < 4; j++) if (dut_mack()[j]) grants.push_back(j);
    endtask

    task automatic idle_inputs();
        rst_v = 0; ack_v = 0;
        for (int j = 0; j < 4; j++) begin cmd_v[j] = 0; addr_v[j] = 0; end
    endtask

    initial begin
        int exp_order[4] = '{1, 2, 1, 2};
        idle_inputs();
        rst_v = 1; tick(); tick();
        rst_v = 0;

        // Core 0 write broadcast, then acks 1,2,3 together, then ack 0.
        cmd_v[0] = 3; addr_v[0] = 32'h1000; tick();
        check_eq("wr_gnt", 64'(dut_mack()), 64'h1);
        cmd_v[0] = 0; tick();
        check_eq("wr_snoop1", 64'(dut_cmd(1)), 64'd1);
        check_eq("wr_addr", 64'(bus.cbus_addr_o), 64'h1000);
        ack_v = 4'b1110; tick();
        check_eq("wr_en", 64'(dut_cmd(0)), 64'd3);
        check_eq("wr_snoop3_off", 64'(dut_cmd(3)), 64'd0);
        ack_v = 4'b0001; tick();
        check_eq("wr_done", 64'(dut_cmd(0)), 64'd0);

        // Cores 1 and 2 keep requesting reads; everyone always acks.
        grants.delete();
        cmd_v[1] = 4; cmd_v[2] = 4; addr_v[1] = 32'h11; addr_v[2] = 32'h22; ack_v = 4'hf;
        for (int i = 0; i < 12; i++) tick();
        check_eq("rr_count", 64'(grants.size()), 64'd4);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            check_eq("rr_order", 64'(grants[i]), 64'(exp_order[i]));
        idle_inputs(); tick(); tick();

        // Staggered snoop acks: core 3 at t, core 1 at t+2, core 2 at t+5.
        cmd_v[0] = 4; addr_v[0] = 32'hbeef; tick();
        cmd_v[0] = 0;
        for (int t = 0; t < 6; t++) begin
            ack_v = 0;
            if (t == 0) ack_v[3] = 1;
            if (t == 2) ack_v[1] = 1;
            if (t == 5) ack_v[2] = 1;
            tick();
        end
        check_eq("stag_en", 64'(dut_cmd(0)), 64'd4);
        ack_v = 4'b0001; tick(); ack_v = 0;

        // Reset while snooping, then cores 2 and 3 request together.
        cmd_v[3] = 3; addr_v[3] = 32'h33; tick();
        cmd_v[3] = 0; tick();
        rst_v = 1; tick();
        check_eq("rst_busy", 64'(bus.busy_o), 64'd0);
        rst_v = 0; cmd_v[2] = 3; cmd_v[3] = 4; addr_v[2] = 32'h22; tick();
        check_eq("rst_gnt", 64'(dut_mack()), 64'h4);
        idle_inputs();

        for (int i = 0; i < 4000; i++) begin
            rst_v = ($urandom_range(0, 99) == 0);
            for (int j = 0; j < 4; j++) begin
                cmd_v[j]  = 3'($urandom_range(0, 7));
                addr_v[j] = $urandom;
                ack_v[j]  = ($urandom_range(0, 2) == 0);
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
